// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: default geometry and FSM encodings.
package mux_scan_ctrl_pkg;

    localparam int unsigned SelWDefault  = 3;
    localparam int unsigned NumChDefault = 8;
    localparam int unsigned SettleW      = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StHold = 2'd2
    } scan_state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Valid/ready word interface between the scan sequencer and its downstream stage.
interface mux_scan_ctrl_if #(
    parameter int unsigned NUM_CH = 8
);
    logic [NUM_CH-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Settle down-counter: reloaded on every select change, done while the count is zero.
module mux_scan_ctrl_settle_timer
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic done_o
);

    logic [SettleW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = SettleW'(SETTLE_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - SettleW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer: steps the mux select, samples y after settling, and hands off the word.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SEL_W         = SelWDefault,
    parameter int unsigned NUM_CH        = NumChDefault,
    parameter int unsigned SETTLE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cont_i,
    output logic [SEL_W-1:0] sel_o,
    input  logic             y_in_i,
    output logic             busy_o,
    mux_scan_ctrl_if.master  out_if
);

    scan_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              busy_q, busy_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic settle_done;
    logic timer_load;
    logic last_ch;
    logic handshake;

    assign last_ch   = (sel_q == SEL_W'(NUM_CH - 1));
    assign handshake = valid_q && out_if.ready;

    // Reload on every select change, including scan (re)start.
    always_comb begin
        timer_load = 1'b0;
        unique case (state_q)
            StIdle:  timer_load = start_i;
            StScan:  timer_load = settle_done;
            StHold:  timer_load = handshake && cont_i;
            default: timer_load = 1'b0;
        endcase
    end

    mux_scan_ctrl_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .done_o (settle_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StScan;
            end
            StScan: begin
                if (settle_done && last_ch) state_d = StHold;
            end
            StHold: begin
                if (handshake) state_d = cont_i ? StScan : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        busy_d   = busy_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sel_d    = '0;
                    busy_d   = 1'b1;
                    shadow_d = '0;
                end
            end
            StScan: begin
                if (settle_done) begin
                    shadow_d[sel_q] = y_in_i;
                    sel_d           = sel_q + SEL_W'(1);
                    if (last_ch) begin
                        // Last bit bypasses the shadow so the word is complete on this edge.
                        data_d             = shadow_q;
                        data_d[NUM_CH-1]   = y_in_i;
                        valid_d            = 1'b1;
                        sel_d              = '0;
                    end
                end
            end
            StHold: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (cont_i) begin
                        sel_d    = '0;
                        shadow_d = '0;
                    end else begin
                        busy_d = 1'b0;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            busy_q   <= 1'b0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign sel_o        = sel_q;
    assign busy_o       = busy_q;
    assign out_if.data  = data_q;
    assign out_if.valid = valid_q;

endmodule
